cphase_stream_engine: RTL

Streaming, parametrised controlled-phase engine for the QFT datapath. It takes one configuration (control qubit, target qubit, precomputed cos/sin of theta) and then a full state vector of 2^NUM_QUBITS packed complex amplitudes, in basis-index order. Every amplitude whose index has both the control and target bits set is multiplied by e^(i*theta); all others pass unchanged. It replaces single-amplitude combinational phase gates with a pipelined, backpressure-aware unit sitting between the state-vector memory reader and writer.

---
 rtl/cphase_stream_engine.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/cphase_stream_engine.sv
// Streaming controlled-phase engine: multiplies amplitudes whose ctrl and tgt index bits are both set by cos+i*sin.
// Latency: 2 cycles from input handshake to m_valid (m_ready high); throughput one amplitude per cycle.
// Backpressure: each stage holds while its successor is full and stalled; m_* outputs stay stable while m_valid && !m_ready.
module cphase_stream_engine #(
    parameter int TOTAL_BITS = 16,
    parameter int FRAC_BITS  = 14,
    parameter int NUM_QUBITS = 3,
    parameter int IDX_BITS   = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [IDX_BITS-1:0]       cfg_ctrl_idx,
    input  logic [IDX_BITS-1:0]       cfg_tgt_idx,
    input  logic [TOTAL_BITS-1:0]     cfg_cos,
    input  logic [TOTAL_BITS-1:0]     cfg_sin,
    output logic                      cfg_err,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [2*TOTAL_BITS-1:0]   s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [2*TOTAL_BITS-1:0]   m_data,
    output logic                      m_last,
    output logic                      busy,
    output logic                      done
);

    localparam int PW = 2 * TOTAL_BITS;   // full product width
    localparam int SW = PW + 1;           // sum/difference of two products

    localparam logic [NUM_QUBITS-1:0] LAST_IDX = '1;
    localparam logic [IDX_BITS:0]     NQ_LIM   = (IDX_BITS + 1)'(NUM_QUBITS);

    // Rounding constant (one half LSB of the result) and saturation bounds, all at sum width.
    localparam logic signed [SW-1:0] HALF = {{(SW - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};
    localparam logic signed [SW-1:0] MAXV = {{(SW - TOTAL_BITS + 1){1'b0}}, {(TOTAL_BITS - 1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW - TOTAL_BITS + 1){1'b1}}, {(TOTAL_BITS - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q;
    logic [IDX_BITS-1:0]     ctrl_q;
    logic [IDX_BITS-1:0]     tgt_q;
    logic [TOTAL_BITS-1:0]   cos_q;
    logic [TOTAL_BITS-1:0]   sin_q;
    logic [NUM_QUBITS-1:0]   in_idx_q;
    logic                    cfg_err_q;
    logic                    done_q;

    // Stage 1: raw products plus the untouched amplitude and its routing flags.
    logic                    s1_vld_q;
    logic signed [PW-1:0]    p_ac_q, p_bs_q, p_as_q, p_bc_q;
    logic [PW-1:0]           s1_raw_q;
    logic                    s1_apply_q;
    logic                    s1_last_q;

    // Stage 2: output register.
    logic                    m_valid_q;
    logic [PW-1:0]           m_data_q;
    logic                    m_last_q;

    logic                    s2_open;
    logic                    s1_open;
    logic                    s_hs;
    logic                    m_hs;
    logic                    cfg_ok;
    logic                    apply_d;
    logic                    last_d;
    logic signed [PW-1:0]    a_ext, b_ext, c_ext, n_ext;
    logic signed [SW-1:0]    re_sum, im_sum;
    logic [TOTAL_BITS-1:0]   re_d, im_d;

    // Round half up, drop the fraction bits, clamp to the signed component range.
    function automatic logic [TOTAL_BITS-1:0] round_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
        r = (v + HALF) >>> FRAC_BITS;
        if (r > MAXV) begin
            return MAXV[TOTAL_BITS-1:0];
        end else if (r < MINV) begin
            return MINV[TOTAL_BITS-1:0];
        end else begin
            return r[TOTAL_BITS-1:0];
        end
    endfunction

    assign s2_open   = !m_valid_q || m_ready;
    assign s1_open   = !s1_vld_q || s2_open;
    assign s_ready   = (state_q == ST_RUN) && s1_open;
    assign s_hs      = s_valid && s_ready;
    assign m_hs      = m_valid_q && m_ready;
    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign cfg_err   = cfg_err_q;
    assign done      = done_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;

    assign cfg_ok  = ({1'b0, cfg_ctrl_idx} < NQ_LIM) && ({1'b0, cfg_tgt_idx} < NQ_LIM);
    assign apply_d = in_idx_q[ctrl_q] & in_idx_q[tgt_q];
    assign last_d  = (in_idx_q == LAST_IDX);

    // Sign-extend operands to product width so each multiply is exact.
    always_comb begin
        a_ext = {{TOTAL_BITS{s_data[PW-1]}}, s_data[PW-1:TOTAL_BITS]};
        b_ext = {{TOTAL_BITS{s_data[TOTAL_BITS-1]}}, s_data[TOTAL_BITS-1:0]};
        c_ext = {{TOTAL_BITS{cos_q[TOTAL_BITS-1]}}, cos_q};
        n_ext = {{TOTAL_BITS{sin_q[TOTAL_BITS-1]}}, sin_q};
    end

    // Complex multiply combine: re = ac - bs, im = as + bc, then round and saturate.
    always_comb begin
        re_sum = {p_ac_q[PW-1], p_ac_q} - {p_bs_q[PW-1], p_bs_q};
        im_sum = {p_as_q[PW-1], p_as_q} + {p_bc_q[PW-1], p_bc_q};
        re_d   = round_sat(re_sum);
        im_d   = round_sat(im_sum);
    end

    // Control FSM: config latch, input index counter, frame completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            tgt_q     <= '0;
            cos_q     <= '0;
            sin_q     <= '0;
            in_idx_q  <= '0;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_ok) begin
                            ctrl_q   <= cfg_ctrl_idx;
                            tgt_q    <= cfg_tgt_idx;
                            cos_q    <= cfg_cos;
                            sin_q    <= cfg_sin;
                            in_idx_q <= '0;
                            state_q  <= ST_RUN;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (s_hs) begin
                        in_idx_q <= in_idx_q + 1'b1;
                        if (last_d) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_hs && m_last_q) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: capture products, raw amplitude, apply and last flags on input handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            p_ac_q     <= '0;
            p_bs_q     <= '0;
            p_as_q     <= '0;
            p_bc_q     <= '0;
            s1_raw_q   <= '0;
            s1_apply_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (s1_open) begin
            s1_vld_q <= s_hs;
            if (s_hs) begin
                p_ac_q     <= a_ext * c_ext;
                p_bs_q     <= b_ext * n_ext;
                p_as_q     <= a_ext * n_ext;
                p_bc_q     <= b_ext * c_ext;
                s1_raw_q   <= s_data;
                s1_apply_q <= apply_d;
                s1_last_q  <= last_d;
            end
        end
    end

    // Stage 2: select rotated or bit-exact raw amplitude into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else if (s2_open) begin
            m_valid_q <= s1_vld_q;
            m_last_q  <= s1_vld_q && s1_last_q;
            if (s1_vld_q) begin
                m_data_q <= s1_apply_q ? {re_d, im_d} : s1_raw_q;
            end
        end
    end

endmodule
